ps2_host_cmd_tx: RTL and testbench
==================================

// Module: ps2_host_cmd_tx
// PURPOSE
// Parametrised PS/2 host-to-device command transmitter. It replaces the fixed F4-only sender with any 8-bit command,
// computed odd parity, ACK checking, a transaction timeout and automatic retry. Sits between the command
// sequencer and the open-drain ps2_clk/ps2_data pads; the top level builds the tri-states from the *_oe outputs.
// PARAMETERS
// CLK_FREQ     50000000  clk_50 frequency in Hz
// INHIBIT_US   120       host clock-low inhibit time (us); INH_CYC = CLK_FREQ/1e6*INHIBIT_US
// TIMEOUT_US   15000     max time from request-to-send to ACK (us); TO_CYC derived the same way
// MAX_RETRY    2         automatic re-sends after NOACK/timeout (0 = none)
// SYNC_STAGES  2         synchroniser depth on ps2_clk_in/ps2_data_in (>=2)
// PORTS
// clk_50       in   1  system clock
// reset        in   1  synchronous, active-high reset
// cmd_valid    in   1  command request
// cmd_data     in   8  command byte (e.g. 8'hF4 enable streaming)
// cmd_ready    out  1  high in IDLE; transfer occurs when cmd_valid&cmd_ready
// ps2_clk_in   in   1  pad ps2_clk level (async)
// ps2_data_in  in   1  pad ps2_data level (async)
// ps2_clk_oe   out  1  1 = pull ps2_clk low, 0 = release
// ps2_data_oe  out  1  1 = pull ps2_data low, 0 = release
// busy         out  1  high in any state other than IDLE
// done         out  1  one-cycle pulse at end of command (success or final failure)
// ack_ok       out  1  valid with done: device ACKed
// err_noack    out  1  valid with done: ACK bit sampled high on final attempt
// err_timeout  out  1  valid with done: TO_CYC expired on final attempt
// BEHAVIOUR
// - Reset (sync): state=IDLE, cmd_ready=1, busy=0, done=0, ack_ok/err_*=0, both oe=0, retry count=0; reset wins mid-frame,
//   oe released on the cycle after reset is sampled.
// - Inputs pass through SYNC_STAGES flops; a falling edge (fe) is prev=1 & cur=0 on the synced clock.
// - Handshake: byte latched on cmd_valid&cmd_ready; frame = {stop=1, parity=~^cmd_data, cmd_data[7:0]} LSB first.
// - States:
//   IDLE    -> INHIBIT on accept.
//   INHIBIT : clk_oe=1, data_oe=0 for exactly INH_CYC cycles -> REQ.
//   REQ     : data_oe=1 (start bit), clk_oe=0 the same cycle; bit_cnt=0, timeout counter cleared -> SHIFT.
//   SHIFT   : on each fe: bit_cnt 0..7 drive data_oe=~cmd[bit_cnt]; bit_cnt 8 drives ~parity; bit_cnt 9 sets data_oe=0 (stop);
//             bit_cnt increments. At bit_cnt 10 -> ACK. Update occurs the cycle after fe is detected.
//   ACK     : on next fe sample synced data: 0 -> ack_ok, 1 -> noack. -> RELEASE.
//   RELEASE : wait until synced clk=1 and data=1 -> DONE (or retry).
//   DONE    : done=1 one cycle with status -> IDLE.
// - Timeout: counter runs in REQ/SHIFT/ACK/RELEASE; reaching TO_CYC aborts the frame with both oe=0.
// - Retry: on noack or timeout with retry count < MAX_RETRY: increment the count and go to INHIBIT with the same byte,
//   with no done pulse. Otherwise -> DONE with the matching err flag (exactly one of ack_ok/err_noack/err_timeout high).
//   The count clears on accept.
// - cmd_valid while busy is ignored (cmd_ready=0); ack_ok/err_* hold their value until the next accept.
// - Never drive clk_oe and data_oe high in SHIFT/ACK/RELEASE; clk_oe=1 only in INHIBIT.
// TESTING
// (CLK_FREQ=1000000 -> 1 cycle/us; device BFM clocks at ~12.5 kHz and ACKs by default)
// 1 cmd 8'hF4 -> clk_oe low 120 cycles, bits 0,0,1,0,1,1,1,1, parity 0, stop 1; ACK -> done with ack_ok=1, 1 attempt.
// 2 cmd 8'hFF -> parity bit 1; cmd 8'h00 -> parity 1; BFM checks received byte and parity match.
// 3 BFM NACKs (data high at ACK) always, MAX_RETRY=2 -> 3 inhibit phases, one done with err_noack=1.
// 4 BFM silent after REQ -> oe released at TO_CYC=15000; after 3 attempts, done with err_timeout=1.
// 5 reset asserted at bit 4 of SHIFT -> next cycle both oe=0, cmd_ready=1; a following 8'hF6 completes ack_ok=1.
// 6 cmd_valid held through busy with data changed -> only the first byte is sent; cmd_ready=0 until done+1.

Source files
------------

// File: rtl/ps2_host_cmd_tx_if.sv
// Command handshake and completion status between the command sequencer and the PS/2 transmitter.
interface ps2_host_cmd_tx_if;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       err_noack;
  logic       err_timeout;

  // Sequencer side: issues commands, observes status
  modport master (
    output cmd_valid, cmd_data,
    input  cmd_ready, busy, done, ack_ok, err_noack, err_timeout
  );

  // Transmitter side: accepts commands, reports status
  modport slave (
    input  cmd_valid, cmd_data,
    output cmd_ready, busy, done, ack_ok, err_noack, err_timeout
  );
endinterface

// File: rtl/ps2_host_cmd_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 8 data bits + odd parity + stop,
// ACK check, per-attempt timeout and automatic retry. Pads are open-drain via the *_oe outputs.
module ps2_host_cmd_tx #(
  parameter int unsigned CLK_FREQ    = 50000000,
  parameter int unsigned INHIBIT_US  = 120,
  parameter int unsigned TIMEOUT_US  = 15000,
  parameter int unsigned MAX_RETRY   = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_50,
  input  logic             reset,
  ps2_host_cmd_tx_if.slave cmd,
  input  logic             ps2_clk_in,
  input  logic             ps2_data_in,
  output logic             ps2_clk_oe,
  output logic             ps2_data_oe
);

  localparam int unsigned CYC_PER_US = CLK_FREQ / 1000000;
  localparam int unsigned INH_CYC    = CYC_PER_US * INHIBIT_US;
  localparam int unsigned TO_CYC     = CYC_PER_US * TIMEOUT_US;
  localparam int unsigned CNT_MAX    = (INH_CYC > TO_CYC) ? INH_CYC : TO_CYC;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
  localparam int unsigned RTY_W      = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_RELEASE, S_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [3:0]               bit_cnt_q, bit_cnt_d;
  logic [RTY_W-1:0]         retry_q, retry_d;
  logic [7:0]               byte_q, byte_d;
  logic                     parity_q, parity_d;
  logic                     nack_q, nack_d;
  logic                     data_oe_q, data_oe_d;
  logic                     clk_oe_q;
  logic                     ready_q, busy_q, done_q;
  logic                     ack_ok_q, ack_ok_d;
  logic                     err_noack_q, err_noack_d;
  logic                     err_timeout_q, err_timeout_d;
  logic [SYNC_STAGES-1:0]   clk_sync_q, data_sync_q;
  logic                     clk_prev_q;
  logic                     clk_s, data_s, fe_c;
  logic                     abort_c, timeout_c;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fe_c   = clk_prev_q & ~clk_s;

  // Synchronise the asynchronous pad levels; idle bus reads high
  always_ff @(posedge clk_50) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_in};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_in};
      clk_prev_q  <= clk_s;
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_cnt_q     <= '0;
      retry_q       <= '0;
      byte_q        <= '0;
      parity_q      <= 1'b0;
      nack_q        <= 1'b0;
      data_oe_q     <= 1'b0;
      clk_oe_q      <= 1'b0;
      ready_q       <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ack_ok_q      <= 1'b0;
      err_noack_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      retry_q       <= retry_d;
      byte_q        <= byte_d;
      parity_q      <= parity_d;
      nack_q        <= nack_d;
      data_oe_q     <= data_oe_d;
      clk_oe_q      <= (state_d == S_INHIBIT);
      ready_q       <= (state_d == S_IDLE);
      busy_q        <= (state_d != S_IDLE);
      done_q        <= (state_d == S_DONE);
      ack_ok_q      <= ack_ok_d;
      err_noack_q   <= err_noack_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Next-state: frame sequencing, timeout and retry decisions
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_cnt_d     = bit_cnt_q;
    retry_d       = retry_q;
    byte_d        = byte_q;
    parity_d      = parity_q;
    nack_d        = nack_q;
    data_oe_d     = data_oe_q;
    ack_ok_d      = ack_ok_q;
    err_noack_d   = err_noack_q;
    err_timeout_d = err_timeout_q;
    abort_c       = 1'b0;
    timeout_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        data_oe_d = 1'b0;
        if (cmd.cmd_valid && ready_q) begin
          state_d       = S_INHIBIT;
          byte_d        = cmd.cmd_data;
          parity_d      = ~^cmd.cmd_data;
          retry_d       = '0;
          cnt_d         = '0;
          ack_ok_d      = 1'b0;
          err_noack_d   = 1'b0;
          err_timeout_d = 1'b0;
        end
      end
      S_INHIBIT: begin
        data_oe_d = 1'b0;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(INH_CYC - 1)) begin
          // start bit goes out together with the clock release
          state_d   = S_REQ;
          data_oe_d = 1'b1;
          cnt_d     = '0;
        end
      end
      S_REQ: begin
        bit_cnt_d = '0;
        nack_d    = 1'b0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        if (bit_cnt_q == 4'd10) begin
          state_d = S_ACK;
        end else if (fe_c) begin
          if (bit_cnt_q < 4'd8)       data_oe_d = ~byte_q[bit_cnt_q[2:0]];
          else if (bit_cnt_q == 4'd8) data_oe_d = ~parity_q;
          else                        data_oe_d = 1'b0;
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      S_ACK: begin
        if (fe_c) begin
          nack_d  = data_s;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (clk_s && data_s) begin
          if (nack_q) begin
            abort_c = 1'b1;
          end else begin
            state_d  = S_DONE;
            ack_ok_d = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Per-attempt watchdog from request-to-send through bus release
    if (state_q inside {S_REQ, S_SHIFT, S_ACK, S_RELEASE}) begin
      if (cnt_q >= CNT_W'(TO_CYC - 1)) timeout_c = 1'b1;
      else                             cnt_d = cnt_q + CNT_W'(1);
    end

    if (abort_c || timeout_c) begin
      data_oe_d = 1'b0;
      cnt_d     = '0;
      ack_ok_d  = 1'b0;
      if (32'(retry_q) < MAX_RETRY) begin
        retry_d = retry_q + RTY_W'(1);
        state_d = S_INHIBIT;
      end else begin
        state_d       = S_DONE;
        err_noack_d   = ~timeout_c;
        err_timeout_d = timeout_c;
      end
    end
  end

  assign ps2_clk_oe      = clk_oe_q;
  assign ps2_data_oe     = data_oe_q;
  assign cmd.cmd_ready   = ready_q;
  assign cmd.busy        = busy_q;
  assign cmd.done        = done_q;
  assign cmd.ack_ok      = ack_ok_q;
  assign cmd.err_noack   = err_noack_q;
  assign cmd.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_ps2_host_cmd_tx.sv
// Directed bench for ps2_host_cmd_tx with a PS/2 device model on open-drain lines (1 cycle = 1 us).
module tb_ps2_host_cmd_tx;

  logic clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  logic reset;
  logic ps2_clk_oe, ps2_data_oe;
  logic dev_clk_low, dev_data_low;
  logic ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_cmd_tx_if ifc ();

  ps2_host_cmd_tx #(
    .CLK_FREQ   (1000000),
    .INHIBIT_US (120),
    .TIMEOUT_US (15000),
    .MAX_RETRY  (2),
    .SYNC_STAGES(2)
  ) dut (
    .clk_50     (clk_50),
    .reset      (reset),
    .cmd        (ifc),
    .ps2_clk_in (ps2_clk_line),
    .ps2_data_in(ps2_data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  int checks = 0;
  int errors = 0;

  // device model state: mode 0 = ACK, 1 = NACK, 2 = silent
  int         dev_mode = 0;
  int         dev_bit = 0;
  int         dev_frames = 0;
  bit         dev_active = 1'b0;
  bit         dev_start_ok = 1'b0;
  logic [9:0] dev_rx = '0;

  // bus monitor
  int inh_run = 0, inh_last = 0, inh_cnt = 0, done_cnt = 0, overlap_cnt = 0;

  always @(negedge clk_50) begin
    if (ps2_clk_oe === 1'b1) inh_run++;
    else if (inh_run != 0) begin
      inh_last = inh_run;
      inh_cnt++;
      inh_run = 0;
    end
    if (ifc.done === 1'b1) done_cnt++;
    if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1) overlap_cnt++;
  end

  // Device: after request-to-send, 11 clock pulses of 40/40 cycles, samples on the high phase
  initial begin
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    forever begin
      wait (ps2_clk_oe === 1'b1);
      wait (ps2_clk_oe === 1'b0);
      repeat (50) @(negedge clk_50);
      dev_start_ok = (ps2_data_line == 1'b0);
      if (dev_mode != 2 && ps2_data_line == 1'b0) begin
        dev_active = 1'b1;
        for (int k = 0; k < 11; k++) begin
          dev_bit = k;
          if (k == 10 && dev_mode == 0) begin
            dev_data_low = 1'b1;
            repeat (5) @(negedge clk_50);
          end
          dev_clk_low = 1'b1;
          repeat (40) @(negedge clk_50);
          dev_clk_low = 1'b0;
          if (k == 10) dev_data_low = 1'b0;
          repeat (20) @(negedge clk_50);
          if (k < 10) dev_rx[k] = ps2_data_line;
          if (k == 9) dev_frames++;
          repeat (20) @(negedge clk_50);
        end
        dev_active = 1'b0;
      end
    end
  end

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk_50);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_data  = b;
    @(negedge clk_50);
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk_50);
      if (ifc.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_data  = 8'h00;
    repeat (3) @(negedge clk_50);
    checks++; if (ifc.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", ifc.cmd_ready); end
    checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", ifc.busy); end
    checks++; if (ifc.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", ifc.done); end
    checks++; if ({ifc.ack_ok, ifc.err_noack, ifc.err_timeout} !== 3'b000) begin errors++; $display("FAIL reset_status got %b exp 000", {ifc.ack_ok, ifc.err_noack, ifc.err_timeout}); end
    checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL reset_oe got %b exp 00", {ps2_clk_oe, ps2_data_oe}); end
    reset = 1'b0;
    repeat (5) @(negedge clk_50);
  endtask

  task automatic test_f4_ack();
    bit seen;
    int f0 = dev_frames, i0 = inh_cnt;
    dev_mode = 0;
    send_cmd(8'hF4);
    checks++; if (ifc.cmd_ready !== 1'b0 || ifc.busy !== 1'b1) begin errors++; $display("FAIL f4_accept ready/busy got %b%b exp 01", ifc.cmd_ready, ifc.busy); end
    wait_done(3000, seen);
    checks++; if (!seen) begin errors++; $display("FAIL f4_done got no done exp done within 3000 cycles"); end
    checks++; if ({ifc.ack_ok, ifc.err_noack, ifc.err_timeout} !== 3'b100) begin errors++; $display("FAIL f4_status got %b exp 100", {ifc.ack_ok, ifc.err_noack, ifc.err_timeout}); end
    checks++; if (inh_last != 120) begin errors++; $display("FAIL f4_inhibit_len got %0d exp 120", inh_last); end
    checks++; if (inh_cnt - i0 != 1) begin errors++; $display("FAIL f4_attempts got %0d exp 1", inh_cnt - i0); end
    checks++; if (dev_rx !== 10'h2F4) begin errors++; $display("FAIL f4_frame got %h exp 2f4", dev_rx); end
    checks++; if (dev_frames - f0 != 1) begin errors++; $display("FAIL f4_frames got %0d exp 1", dev_frames - f0); end
    checks++; if (dev_start_ok !== 1'b1) begin errors++; $display("FAIL f4_start_bit got %b exp 1", dev_start_ok); end
    @(negedge clk_50);
    checks++; if (ifc.cmd_ready !== 1'b1 || ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin errors++; $display("FAIL f4_idle ready/busy/done got %b%b%b exp 100", ifc.cmd_ready, ifc.busy, ifc.done); end
    repeat (100) @(negedge clk_50);
  endtask

  task automatic test_parity();
    logic [7:0] cmds [2];
    logic [9:0] frames [2];
    bit seen;
    cmds[0] = 8'hFF; frames[0] = 10'h3FF;
    cmds[1] = 8'h00; frames[1] = 10'h300;
    dev_mode = 0;
    for (int i = 0; i < 2; i++) begin
      send_cmd(cmds[i]);
      wait_done(3000, seen);
      checks++; if (!seen || ifc.ack_ok !== 1'b1) begin errors++; $display("FAIL parity_ack cmd %h got seen=%b ack_ok=%b exp 1 1", cmds[i], seen, ifc.ack_ok); end
      checks++; if (dev_rx !== frames[i]) begin errors++; $display("FAIL parity_frame cmd %h got %h exp %h", cmds[i], dev_rx, frames[i]); end
      repeat (100) @(negedge clk_50);
    end
  endtask

  task automatic test_nack_retry();
    bit seen;
    int f0 = dev_frames, i0 = inh_cnt, d0 = done_cnt;
    dev_mode = 1;
    send_cmd(8'hF4);
    wait_done(6000, seen);
    checks++; if (!seen) begin errors++; $display("FAIL nack_done got no done exp done within 6000 cycles"); end
    checks++; if ({ifc.ack_ok, ifc.err_noack, ifc.err_timeout} !== 3'b010) begin errors++; $display("FAIL nack_status got %b exp 010", {ifc.ack_ok, ifc.err_noack, ifc.err_timeout}); end
    checks++; if (inh_cnt - i0 != 3) begin errors++; $display("FAIL nack_inhibits got %0d exp 3", inh_cnt - i0); end
    checks++; if (dev_frames - f0 != 3) begin errors++; $display("FAIL nack_frames got %0d exp 3", dev_frames - f0); end
    repeat (200) @(negedge clk_50);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL nack_done_pulses got %0d exp 1", done_cnt - d0); end
    dev_mode = 0;
  endtask

  task automatic test_timeout();
    bit seen;
    int hi_len = 0;
    int i0 = inh_cnt;
    dev_mode = 2;
    send_cmd(8'hF4);
    for (int i = 0; i < 400 && ps2_data_oe !== 1'b1; i++) @(negedge clk_50);
    while (ps2_data_oe === 1'b1 && hi_len < 20000) begin
      hi_len++;
      @(negedge clk_50);
    end
    checks++; if (hi_len != 15000) begin errors++; $display("FAIL timeout_req_len got %0d exp 15000", hi_len); end
    wait_done(40000, seen);
    checks++; if (!seen) begin errors++; $display("FAIL timeout_done got no done exp done within 40000 cycles"); end
    checks++; if ({ifc.ack_ok, ifc.err_noack, ifc.err_timeout} !== 3'b001) begin errors++; $display("FAIL timeout_status got %b exp 001", {ifc.ack_ok, ifc.err_noack, ifc.err_timeout}); end
    checks++; if (inh_cnt - i0 != 3) begin errors++; $display("FAIL timeout_inhibits got %0d exp 3", inh_cnt - i0); end
    checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL timeout_oe got %b exp 00", {ps2_clk_oe, ps2_data_oe}); end
    repeat (50) @(negedge clk_50);
    checks++; if (ifc.err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_hold got %b exp 1", ifc.err_timeout); end
    dev_mode = 0;
  endtask

  task automatic test_reset_midframe();
    bit seen;
    bit hit = 1'b0;
    send_cmd(8'h00);
    checks++; if (ifc.err_timeout !== 1'b0) begin errors++; $display("FAIL status_clear_on_accept got %b exp 0", ifc.err_timeout); end
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_50);
      if (dev_active && dev_bit == 4) begin hit = 1'b1; break; end
    end
    checks++; if (!hit || ps2_data_oe !== 1'b1) begin errors++; $display("FAIL midframe_reach got hit=%b data_oe=%b exp 1 1", hit, ps2_data_oe); end
    reset = 1'b1;
    @(negedge clk_50);
    checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL midframe_oe got %b exp 00", {ps2_clk_oe, ps2_data_oe}); end
    checks++; if (ifc.cmd_ready !== 1'b1 || ifc.busy !== 1'b0) begin errors++; $display("FAIL midframe_ready/busy got %b%b exp 10", ifc.cmd_ready, ifc.busy); end
    reset = 1'b0;
    for (int i = 0; i < 2000 && dev_active; i++) @(negedge clk_50);
    repeat (50) @(negedge clk_50);
    send_cmd(8'hF6);
    wait_done(3000, seen);
    checks++; if (!seen || ifc.ack_ok !== 1'b1) begin errors++; $display("FAIL after_reset_ack got seen=%b ack_ok=%b exp 1 1", seen, ifc.ack_ok); end
    checks++; if (dev_rx !== 10'h3F6) begin errors++; $display("FAIL after_reset_frame got %h exp 3f6", dev_rx); end
    repeat (100) @(negedge clk_50);
  endtask

  task automatic test_back_to_back();
    bit seen = 1'b0;
    int ready_hi = 0;
    int f0 = dev_frames;
    @(negedge clk_50);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_data  = 8'hF4;
    @(negedge clk_50);
    ifc.cmd_data  = 8'h12;
    for (int i = 0; i < 3000; i++) begin
      if (ifc.done === 1'b1) begin seen = 1'b1; break; end
      if (ifc.cmd_ready !== 1'b0) ready_hi++;
      @(negedge clk_50);
    end
    checks++; if (!seen) begin errors++; $display("FAIL b2b_done got no done exp done within 3000 cycles"); end
    checks++; if (ready_hi != 0) begin errors++; $display("FAIL b2b_ready_while_busy got %0d cycles exp 0", ready_hi); end
    checks++; if (ifc.cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_at_done got %b exp 0", ifc.cmd_ready); end
    ifc.cmd_valid = 1'b0;
    @(negedge clk_50);
    checks++; if (ifc.cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_done got %b exp 1", ifc.cmd_ready); end
    checks++; if (dev_rx !== 10'h2F4 || dev_frames - f0 != 1) begin errors++; $display("FAIL b2b_frame got %h/%0d exp 2f4/1", dev_rx, dev_frames - f0); end
    repeat (20) @(negedge clk_50);
    checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL b2b_no_second_send got busy=%b exp 0", ifc.busy); end
  endtask

  initial begin
    test_reset();
    test_f4_ack();
    test_parity();
    test_nack_retry();
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
    checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL oe_overlap got %0d cycles exp 0", overlap_cnt); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
